fir_coef_config_ctrl: RTL



---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_cfg_timeout.sv | 29 ++
 rtl/fir_coef_config_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the FIR coefficient configuration sequencer.
package fir_pkg;

  localparam int unsigned COEF_W   = 16;
  localparam int unsigned MAX_TAPS = 16;
  localparam int unsigned ADDR_W   = 4;

  localparam logic [7:0]        TIMEOUT_CYC = 8'd255;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MAX_TAPS - 1);

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WAIT_EN = 6'b000010,
    ST_LOAD    = 6'b000100,
    ST_ZERO    = 6'b001000,
    ST_COMMIT  = 6'b010000,
    ST_ERR     = 6'b100000
  } state_t;

endpackage

// File: rtl/fir_cfg_timeout.sv
// Idle-cycle watchdog for the coefficient stream; saturates at TIMEOUT_CYC.
module fir_cfg_timeout
  import fir_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] idle_cnt_r;

  // Idle counter: cleared on accept or outside LOAD, counts idle LOAD cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= 8'd0;
    end else if (clr) begin
      idle_cnt_r <= 8'd0;
    end else if (en && (idle_cnt_r != TIMEOUT_CYC)) begin
      idle_cnt_r <= idle_cnt_r + 8'd1;
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  assign expire = en & (idle_cnt_r == TIMEOUT_CYC);

endmodule

// File: rtl/fir_coef_config_ctrl.sv
// Loads a burst of coefficient words into the coefficient file, zero-fills the
// unused taps and publishes the new tap count only after a clean load.
module fir_coef_config_ctrl
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_tap_num,
  input  logic              config_enable,
  input  logic              cfg_valid,
  input  logic [COEF_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [COEF_W-1:0] coef_wdata,
  output logic [ADDR_W-1:0] tap_num_q,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error
);

  state_t              state_r, state_s;
  logic                cfg_ready_s, accept_s, expire_s;
  logic [ADDR_W-1:0]   tap_shadow_r, addr_cnt_r, coef_addr_r, tap_num_q_r;
  logic [COEF_W-1:0]   coef_wdata_r;
  logic                coef_we_r, cfg_busy_r, cfg_done_r, cfg_error_r;

  fir_cfg_timeout u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept_s | (state_r != ST_LOAD)),
    .en     (state_r == ST_LOAD),
    .expire (expire_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, ready and accept decode; an enable drop outranks the timeout
  always_comb begin
    state_s     = state_r;
    cfg_ready_s = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) state_s = ST_WAIT_EN;
        else           state_s = ST_IDLE;
      end
      ST_WAIT_EN: begin
        if (config_enable) state_s = ST_LOAD;
        else               state_s = ST_WAIT_EN;
      end
      ST_LOAD: begin
        cfg_ready_s = config_enable;
        accept_s    = cfg_valid & config_enable;
        if (!config_enable) begin
          state_s = ST_ERR;
        end else if (accept_s) begin
          if (addr_cnt_r == tap_shadow_r) begin
            if (tap_shadow_r < LAST_ADDR) state_s = ST_ZERO;
            else                          state_s = ST_COMMIT;
          end else begin
            state_s = ST_LOAD;
          end
        end else if (expire_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_ZERO: begin
        if (!config_enable)              state_s = ST_ERR;
        else if (addr_cnt_r == LAST_ADDR) state_s = ST_COMMIT;
        else                             state_s = ST_ZERO;
      end
      ST_COMMIT: state_s = ST_IDLE;
      ST_ERR:    state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Datapath: write port, address counter, commit and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_shadow_r <= '0;
      addr_cnt_r   <= '0;
      coef_we_r    <= 1'b0;
      coef_addr_r  <= '0;
      coef_wdata_r <= '0;
      tap_num_q_r  <= '0;
      cfg_busy_r   <= 1'b0;
      cfg_done_r   <= 1'b0;
      cfg_error_r  <= 1'b0;
    end else begin
      coef_we_r  <= 1'b0;
      cfg_done_r <= 1'b0;
      cfg_busy_r <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            tap_shadow_r <= cfg_tap_num;
            addr_cnt_r   <= '0;
            cfg_error_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            coef_we_r    <= 1'b1;
            coef_addr_r  <= addr_cnt_r;
            coef_wdata_r <= cfg_data;
            if (addr_cnt_r != LAST_ADDR) addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
          end
        end
        ST_ZERO: begin
          if (config_enable) begin
            coef_we_r    <= 1'b1;
            coef_addr_r  <= addr_cnt_r;
            coef_wdata_r <= '0;
            if (addr_cnt_r != LAST_ADDR) addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
          end
        end
        ST_COMMIT: begin
          tap_num_q_r <= tap_shadow_r;
          cfg_done_r  <= 1'b1;
        end
        ST_ERR:  cfg_error_r <= 1'b1;
        default: ;
      endcase
    end
  end

  assign cfg_ready  = cfg_ready_s;
  assign coef_we    = coef_we_r;
  assign coef_addr  = coef_addr_r;
  assign coef_wdata = coef_wdata_r;
  assign tap_num_q  = tap_num_q_r;
  assign cfg_busy   = cfg_busy_r;
  assign cfg_done   = cfg_done_r;
  assign cfg_error  = cfg_error_r;

endmodule
